vec_store_seq: RTL and testbench

//  Vector store sequencer. Accepts one store request per transfer (source vreg, beat count, base address).

---
 rtl/vec_store_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_vec_store_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_store_seq.sv
// vec_store_seq: vector store sequencer.
// Accepts one store request at a time (source vreg, beat count, base byte address).
// It walks the register file store read port and absorbs the port's one-cycle read
// latency in a 2-entry FIFO. Beats stream to memory under valid/ready.
//
// Optional feature macro: VEC_STORE_REG_GROUP_EN
//   defined   : register-group stores. The beat count clamps to 8*BPR, and the
//               register index advances (wrapping) every BPR beats.
//   undefined : single-register stores. The beat count clamps to BPR.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake (ready only while idle)
//   req_vreg_i            source vector register
//   req_beats_i           beats to store (0 allowed, clamped)
//   req_base_i            byte address of beat 0
//   req_last_be_i         byte enables for the final beat
//   st_en_o/addr_o/off_o  register-file store read port (data returns next cycle)
//   st_data_i             register-file read data
//   mem_*                 beat stream to memory (valid/ready, addr, data, be, last)
//   done_o                one-cycle pulse when the transfer completes
module vec_store_seq #(
    parameter int VLEN       = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int DW_B       = DATA_WIDTH / 8,
    parameter int OFF_BITS   = 8,
    parameter int MEM_AW     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_vreg_i,
    input  logic [OFF_BITS:0]     req_beats_i,
    input  logic [MEM_AW-1:0]     req_base_i,
    input  logic [DW_B-1:0]       req_last_be_i,
    output logic [DW_B-1:0]       st_en_o,
    output logic [ADDR_WIDTH-1:0] st_addr_o,
    output logic [OFF_BITS-1:0]   st_off_o,
    input  logic [DATA_WIDTH-1:0] st_data_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [DW_B-1:0]       mem_be_o,
    output logic                  mem_last_o,
    output logic                  done_o
);

    localparam int BPR = VLEN / DATA_WIDTH;
`ifdef VEC_STORE_REG_GROUP_EN
    localparam int MAX_BEATS = 8 * BPR;
`else
    localparam int MAX_BEATS = BPR;
`endif
    localparam logic [OFF_BITS:0]   MAX_B   = (OFF_BITS+1)'(MAX_BEATS);
    localparam logic [OFF_BITS:0]   ONE_B   = (OFF_BITS+1)'(1);
    localparam logic [OFF_BITS-1:0] ONE_OFF = OFF_BITS'(1);
    localparam logic [MEM_AW-1:0]   STRIDE  = MEM_AW'(DW_B);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   vreg_q, vreg_d;
    logic [OFF_BITS-1:0]     off_q, off_d;
    logic [OFF_BITS:0]       cnt_q, cnt_d;
    logic [OFF_BITS:0]       beats_q, beats_d;
    logic [DW_B-1:0]         last_be_q, last_be_d;
    logic [MEM_AW-1:0]       iss_addr_q, iss_addr_d;

    // Tag of the read in flight; it joins the returning data in the FIFO.
    logic                    inf_q, inf_d;
    logic [DW_B-1:0]         inf_be_q, inf_be_d;
    logic                    inf_last_q, inf_last_d;
    logic [MEM_AW-1:0]       inf_addr_q, inf_addr_d;

    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic [DW_B-1:0]         fifo_be_q   [2];
    logic                    fifo_last_q [2];
    logic [MEM_AW-1:0]       fifo_addr_q [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;

    logic [OFF_BITS:0]       req_clamped;
    logic [1:0]              credit;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    is_last_issue;

    assign req_clamped   = (req_beats_i > MAX_B) ? MAX_B : req_beats_i;
    // Slots already committed: beats buffered plus the read whose data is returning.
    assign credit        = count_q + {1'b0, inf_q};
    assign issue         = (state_q == S_RUN) && (credit < 2'd2);
    assign push          = inf_q;
    assign pop           = mem_valid_o && mem_ready_i;
    assign is_last_issue = (cnt_q == beats_q - ONE_B);

    assign req_ready_o = (state_q == S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign st_en_o     = issue ? {DW_B{1'b1}} : '0;
    assign st_addr_o   = issue ? vreg_q : '0;
    assign st_off_o    = issue ? off_q : '0;

    assign mem_valid_o = (count_q != 2'd0);
    assign mem_addr_o  = mem_valid_o ? fifo_addr_q[rd_ptr_q] : '0;
    assign mem_data_o  = mem_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign mem_be_o    = mem_valid_o ? fifo_be_q[rd_ptr_q]   : '0;
    assign mem_last_o  = mem_valid_o && fifo_last_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        vreg_d     = vreg_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        beats_d    = beats_q;
        last_be_d  = last_be_q;
        iss_addr_d = iss_addr_q;
        inf_d      = issue;
        inf_be_d   = inf_be_q;
        inf_last_d = inf_last_q;
        inf_addr_d = inf_addr_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    vreg_d     = req_vreg_i;
                    off_d      = '0;
                    cnt_d      = '0;
                    beats_d    = req_clamped;
                    last_be_d  = req_last_be_i;
                    iss_addr_d = req_base_i;
                    state_d    = (req_clamped == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    inf_last_d = is_last_issue;
                    inf_be_d   = is_last_issue ? last_be_q : {DW_B{1'b1}};
                    inf_addr_d = iss_addr_q;
                    iss_addr_d = iss_addr_q + STRIDE;
                    cnt_d      = cnt_q + ONE_B;
`ifdef VEC_STORE_REG_GROUP_EN
                    if (off_q == OFF_BITS'(BPR - 1)) begin
                        off_d  = '0;
                        vreg_d = vreg_q + ADDR_WIDTH'(1);
                    end else begin
                        off_d  = off_q + ONE_OFF;
                    end
`else
                    off_d      = off_q + ONE_OFF;
`endif
                    if (is_last_issue) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the final beat retires so done follows its handshake directly.
                if (!inf_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vreg_q     <= '0;
            off_q      <= '0;
            cnt_q      <= '0;
            beats_q    <= '0;
            last_be_q  <= '0;
            iss_addr_q <= '0;
            inf_q      <= 1'b0;
            inf_be_q   <= '0;
            inf_last_q <= 1'b0;
            inf_addr_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            vreg_q     <= vreg_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
            beats_q    <= beats_d;
            last_be_q  <= last_be_d;
            iss_addr_q <= iss_addr_d;
            inf_q      <= inf_d;
            inf_be_q   <= inf_be_d;
            inf_last_q <= inf_last_d;
            inf_addr_q <= inf_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_be_q[i]   <= '0;
                fifo_last_q[i] <= 1'b0;
                fifo_addr_q[i] <= '0;
            end
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= st_data_i;
            fifo_be_q[wr_ptr_q]   <= inf_be_q;
            fifo_last_q[wr_ptr_q] <= inf_last_q;
            fifo_addr_q[wr_ptr_q] <= inf_addr_q;
        end
    end

endmodule

// File: tb/tb_vec_store_seq.sv
module tb_vec_store_seq;

    localparam int BPR = 2;
`ifdef VEC_STORE_REG_GROUP_EN
    localparam int MAXB = 8 * BPR;
`else
    localparam int MAXB = BPR;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic        last;
    } beat_t;

    typedef struct {
        logic [4:0] vreg;
        logic [7:0] off;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_vreg = '0;
    logic [8:0]  req_beats = '0;
    logic [31:0] req_base = '0;
    logic [7:0]  req_last_be = '0;
    logic [7:0]  st_en;
    logic [4:0]  st_addr;
    logic [7:0]  st_off;
    logic [63:0] st_data = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [63:0] mem_data;
    logic [7:0]  mem_be;
    logic        mem_last;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [63:0] rf_mem [0:32*BPR-1];

    vec_store_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_vreg_i    (req_vreg),
        .req_beats_i   (req_beats),
        .req_base_i    (req_base),
        .req_last_be_i (req_last_be),
        .st_en_o       (st_en),
        .st_addr_o     (st_addr),
        .st_off_o      (st_off),
        .st_data_i     (st_data),
        .mem_valid_o   (mem_valid),
        .mem_ready_i   (mem_ready),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_data),
        .mem_be_o      (mem_be),
        .mem_last_o    (mem_last),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    // Register file store port: data returns one cycle after the read enable.
    always @(posedge clk) begin
        if (st_en != 8'h00) st_data <= rf_mem[int'(st_addr) * BPR + int'(st_off)];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_st_en"}, st_en, 0);
        chk({tag, "_st_addr"}, st_addr, 0);
        chk({tag, "_st_off"}, st_off, 0);
        chk({tag, "_mem_valid"}, mem_valid, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_mem_be"}, mem_be, 0);
        chk({tag, "_mem_last"}, mem_last, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode 0: memory always ready; 1: random ready; 2: ready held low for the first cycles.
    task automatic run_req(input logic [4:0] v, input int beats, input logic [31:0] base,
                           input logic [7:0] lbe, input int mode, input bit abort);
        beat_t bq[$];
        rd_t   iq[$];
        int    n;
        int    issued;
        int    accepted;
        bit    last_hs;
        bit    done_exp;
        bit    hs;
        bit    finished;
        n = (beats > MAXB) ? MAXB : beats;
        for (int k = 0; k < n; k++) begin
            beat_t b;
            rd_t   r;
`ifdef VEC_STORE_REG_GROUP_EN
            r.vreg = 5'((int'(v) + k / BPR) % 32);
`else
            r.vreg = v;
`endif
            r.off  = 8'(k % BPR);
            b.addr = base + 32'(k * 8);
            b.data = rf_mem[int'(r.vreg) * BPR + int'(r.off)];
            b.be   = (k == n - 1) ? lbe : 8'hFF;
            b.last = (k == n - 1);
            bq.push_back(b);
            iq.push_back(r);
        end

        @(negedge clk);
        req_valid   = 1'b1;
        req_vreg    = v;
        req_beats   = beats[8:0];
        req_base    = base;
        req_last_be = lbe;
        mem_ready   = 1'b0;
        #1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk);

        issued   = 0;
        accepted = 0;
        last_hs  = 1'b0;
        finished = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            @(negedge clk);
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom % 2);
                default: mem_ready = (c >= 7);
            endcase
            // Garbage request held valid: must be ignored while busy.
            req_vreg  = 5'($urandom);
            req_beats = 9'($urandom);
            req_base  = $urandom;
            #1;
            chk("req_ready_busy", req_ready, 0);
            done_exp = (n == 0 && c == 0) || last_hs;
            chk("done", done, done_exp);
            if (c == 0 && n > 0) chk("first_issue", st_en != 8'h00, 1);
            if (c == 2 && n > 0) chk("first_valid", mem_valid, 1);

            if (st_en != 8'h00) begin
                if (iq.size() == 0) begin
                    chk("extra_issue", 1, 0);
                end else begin
                    chk("st_en", st_en, 8'hFF);
                    chk("st_addr", st_addr, iq[0].vreg);
                    chk("st_off", st_off, iq[0].off);
                    chk("outstanding_le2", (issued - accepted) <= 1, 1);
                    void'(iq.pop_front());
                    issued++;
                end
            end

            hs = 1'b0;
            last_hs = 1'b0;
            if (mem_valid) begin
                if (bq.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("mem_addr", mem_addr, bq[0].addr);
                    chk("mem_data", mem_data, bq[0].data);
                    chk("mem_be", mem_be, bq[0].be);
                    chk("mem_last", mem_last, bq[0].last);
                    if (mem_ready) begin
                        hs = 1'b1;
                        last_hs = bq[0].last;
                        void'(bq.pop_front());
                        accepted++;
                    end
                end
            end

            if (done_exp || done) begin
                finished = 1'b1;
                req_valid = 1'b0;
                chk("beats_left", bq.size(), 0);
            end else if (c == 299) begin
                chk("timeout", 0, 1);
            end

            if (abort && hs && !finished) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk_idle_outputs("reset_mid");
                @(negedge clk);
                req_valid = 1'b0;
                mem_ready = 1'b0;
                rst_n = 1'b1;
                finished = 1'b1;
            end
        end
        if (!finished) req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32 * BPR; i++) rf_mem[i] = {$urandom, $urandom};

        #12;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_idle_outputs("after_reset");

        run_req(5'd3, 2, 32'h0000_1000, 8'hFF, 0, 1'b0);
        run_req(5'd3, 2, 32'h0000_1000, 8'hFF, 2, 1'b0);
        run_req(5'd7, 0, 32'h0000_2000, 8'hFF, 0, 1'b0);
        run_req(5'd9, 1, 32'h0000_3000, 8'h0F, 0, 1'b0);
        run_req(5'd4, 2, 32'h0000_4000, 8'h3C, 1, 1'b1);
        run_req(5'd5, 2, 32'h0000_5000, 8'h81, 0, 1'b0);
        run_req(5'd12, 300, 32'h0000_6000, 8'h01, 0, 1'b0);
        run_req(5'd20, 2, 32'hFFFF_FFF8, 8'hF0, 0, 1'b0);
`ifdef VEC_STORE_REG_GROUP_EN
        run_req(5'd31, 5, 32'hFFFF_FFF8, 8'h0F, 0, 1'b0);
        run_req(5'd30, MAXB, 32'h0000_8000, 8'hAA, 1, 1'b0);
`endif

        for (int t = 0; t < 25; t++) begin
            run_req(5'($urandom), int'($urandom_range(0, MAXB + 2)), $urandom & 32'hFFFF_FFF8,
                    8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
